// File: rtl/sid_i2s_tx.sv
// rtl/sid_i2s_tx.sv - mono 16-bit sample stream to I2S (Philips) master serializer
// Generates BCLK/LRCLK from CLK and ships each held sample on both channels.
module sid_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic signed [15:0] SAMPLE,
  input  logic               SAMPLE_VALID,
  output logic               BCLK,
  output logic               LRCLK,
  output logic               SDATA,
  output logic               FRAME_START,
  output logic               OVERRUN,
  output logic               UNDERRUN
);

  localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [15:0]      hold;
  logic             pending;
  logic [31:0]      frame_word;

  logic             div_tc;
  logic             fall_evt;
  logic             latch;
  logic [4:0]       bit_nxt;
  logic [4:0]       sdata_idx;
  logic             sdata_nxt;

  always_comb begin
    div_tc    = (div_cnt == DIV_LAST);
    fall_evt  = div_tc & BCLK;
    bit_nxt   = bit_cnt + 5'd1;
    latch     = fall_evt & (bit_cnt == 5'd0);
    // Bit k of the frame is word[32-k]; k=0 wraps to word[0] of the outgoing word.
    sdata_idx = 5'd0 - bit_nxt;
    // The MSB goes out on the very edge the new word is latched, so take it from hold.
    sdata_nxt = (bit_nxt == 5'd1) ? hold[15] : frame_word[sdata_idx];
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      div_cnt     <= '0;
      BCLK        <= 1'b0;
      bit_cnt     <= 5'd31;
      LRCLK       <= 1'b1;
      SDATA       <= 1'b0;
      frame_word  <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      FRAME_START <= 1'b0;
      OVERRUN     <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) begin
        BCLK <= ~BCLK;
      end
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        LRCLK   <= bit_nxt[4];
        SDATA   <= sdata_nxt;
      end
      if (latch) begin
        frame_word <= {hold, hold};
      end
      if (SAMPLE_VALID) begin
        hold <= SAMPLE;
      end
      // A strobe on the latch cycle becomes the next pending sample.
      pending     <= SAMPLE_VALID | (pending & ~latch);
      FRAME_START <= latch;
      UNDERRUN    <= latch & ~pending;
      OVERRUN     <= SAMPLE_VALID & pending & ~latch;
    end
  end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb/tb_sid_i2s_tx.sv - directed bench for sid_i2s_tx (BCLK_DIV=4 and BCLK_DIV=1 instances)
module tb_sid_i2s_tx;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [15:0] sample4, sample1;
  logic        valid4, valid1;
  logic        bclk4, lr4, sd4, fs4, ov4, un4;
  logic        bclk1, lr1, sd1, fs1, ov1, un1;
  logic        sel;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  wire sd_s = sel ? sd1 : sd4;
  wire lr_s = sel ? lr1 : lr4;
  wire fs_s = sel ? fs1 : fs4;
  wire ov_s = sel ? ov1 : ov4;
  wire un_s = sel ? un1 : un4;

  sid_i2s_tx #(.BCLK_DIV(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .SAMPLE(sample4), .SAMPLE_VALID(valid4),
    .BCLK(bclk4), .LRCLK(lr4), .SDATA(sd4),
    .FRAME_START(fs4), .OVERRUN(ov4), .UNDERRUN(un4)
  );

  sid_i2s_tx #(.BCLK_DIV(1)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .SAMPLE(sample1), .SAMPLE_VALID(valid1),
    .BCLK(bclk1), .LRCLK(lr1), .SDATA(sd1),
    .FRAME_START(fs1), .OVERRUN(ov1), .UNDERRUN(un1)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    if (sel) begin
      sample1 = v;
      valid1  = 1'b1;
    end else begin
      sample4 = v;
      valid4  = 1'b1;
    end
    step(1);
    valid1 = 1'b0;
    valid4 = 1'b0;
  endtask

  task automatic wait_frame(input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!fs_s && n < max);
    checks++;
    if (fs_s !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: FRAME_START=%b after %0d CLK, want 1", fs_s, max);
    end
  endtask

  // Starts on the latch edge (k=1); ends on the k=0 edge of the following frame.
  task automatic capture(input int div, output logic [31:0] w, output logic [31:0] l,
                         output logic stray);
    w[31] = sd_s;
    l[31] = lr_s;
    stray = 1'b0;
    for (int k = 1; k < 32; k++) begin
      for (int j = 0; j < 2 * div; j++) begin
        step(1);
        if (ov_s || un_s || fs_s) stray = 1'b1;
      end
      w[31-k] = sd_s;
      l[31-k] = lr_s;
    end
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({bclk4, lr4, sd4, fs4, ov4, un4} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_div4: outputs=%b want 010000", {bclk4, lr4, sd4, fs4, ov4, un4});
    end
    checks++;
    if ({bclk1, lr1, sd1, fs1, ov1, un1} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_div1: outputs=%b want 010000", {bclk1, lr1, sd1, fs1, ov1, un1});
    end
  endtask

  task automatic test_startup(input string tag);
    logic [5:0] exp;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      exp = {((e / 4) % 2) == 1, e < 8, 1'b0, e == 16, 1'b0, e == 16};
      checks++;
      if ({bclk4, lr4, sd4, fs4, ov4, un4} !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: {bclk,lr,sd,fs,ov,un}=%b want %b",
                 tag, e, {bclk4, lr4, sd4, fs4, ov4, un4}, exp);
      end
    end
  endtask

  task automatic test_mono();
    logic [31:0] w, l;
    logic        p;
    int          n;
    strobe(16'h8001);
    wait_frame(300, n);
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL mono_period: latch after %0d CLK, want 255", n);
    end
    checks++;
    if (un4 !== 1'b0) begin
      errors++;
      $display("FAIL mono_underrun: UNDERRUN=%b want 0", un4);
    end
    capture(4, w, l, p);
    checks++;
    if (w !== 32'h8001_8001) begin
      errors++;
      $display("FAIL mono_word: got %h want 80018001", w);
    end
    checks++;
    if (l !== 32'h0001_FFFE) begin
      errors++;
      $display("FAIL mono_lrclk: got %h want 0001fffe", l);
    end
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL mono_stray: stray pulse=%b want 0", p);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] w, l;
    logic        p;
    int          n;
    strobe(16'h1234);
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: OVERRUN=%b want 0", ov4);
    end
    step(1);
    strobe(16'hABCD);
    checks++;
    if (ov4 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: OVERRUN=%b want 1", ov4);
    end
    step(1);
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_width: OVERRUN=%b want 0", ov4);
    end
    wait_frame(20, n);
    checks++;
    if (n != 4 || un4 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_latch: wait=%0d UNDERRUN=%b want 4 0", n, un4);
    end
    capture(4, w, l, p);
    checks++;
    if (w !== 32'hABCD_ABCD || l !== 32'h0001_FFFE || p !== 1'b0) begin
      errors++;
      $display("FAIL ovr_frame: word=%h lr=%h stray=%b want abcdabcd 0001fffe 0", w, l, p);
    end
  endtask

  task automatic test_latch_collision();
    logic [31:0] w, l;
    logic        p;
    int          n;
    step(7);
    strobe(16'h5555);
    checks++;
    if ({fs4, un4, ov4} !== 3'b110) begin
      errors++;
      $display("FAIL coll_latch: {fs,un,ov}=%b want 110", {fs4, un4, ov4});
    end
    capture(4, w, l, p);
    checks++;
    if (w !== 32'hABCD_ABCD || p !== 1'b0) begin
      errors++;
      $display("FAIL coll_old_frame: word=%h stray=%b want abcdabcd 0", w, p);
    end
    wait_frame(20, n);
    checks++;
    if (n != 8 || un4 !== 1'b0) begin
      errors++;
      $display("FAIL coll_next_latch: wait=%0d UNDERRUN=%b want 8 0", n, un4);
    end
    capture(4, w, l, p);
    checks++;
    if (w !== 32'h5555_5555 || p !== 1'b0) begin
      errors++;
      $display("FAIL coll_new_frame: word=%h stray=%b want 55555555 0", w, p);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, l;
    logic        p;
    int          n;
    wait_frame(20, n);
    checks++;
    if (n != 8 || un4 !== 1'b1) begin
      errors++;
      $display("FAIL mid_latch: wait=%0d UNDERRUN=%b want 8 1", n, un4);
    end
    step(152);
    checks++;
    if ({bclk4, lr4} !== 2'b01) begin
      errors++;
      $display("FAIL mid_k20: {bclk,lr}=%b want 01", {bclk4, lr4});
    end
    step(4);
    checks++;
    if ({bclk4, sd4} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre: {bclk,sd}=%b want 11", {bclk4, sd4});
    end
    #2;
    RESETn = 1'b0;
    #1;
    checks++;
    if ({bclk4, lr4, sd4, fs4, ov4, un4} !== 6'b010000) begin
      errors++;
      $display("FAIL mid_async: outputs=%b want 010000", {bclk4, lr4, sd4, fs4, ov4, un4});
    end
    test_startup("restart");
    capture(4, w, l, p);
    checks++;
    if (w !== 32'h0 || l !== 32'h0001_FFFE || p !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold_cleared: word=%h lr=%h stray=%b want 0 0001fffe 0", w, l, p);
    end
  endtask

  task automatic test_div1();
    logic [15:0] vals [4];
    logic [31:0] w, l;
    logic        p, prev, bad, flag;
    int          n;
    vals = '{16'h1357, 16'h2468, 16'hF00F, 16'h7EC1};
    sel = 1'b1;
    wait_frame(200, n);
    strobe(vals[0]);
    for (int f = 0; f < 4; f++) begin
      n    = 0;
      bad  = 1'b0;
      flag = 1'b0;
      prev = bclk1;
      do begin
        step(1);
        n++;
        if (bclk1 === prev) bad = 1'b1;
        prev = bclk1;
        if (ov1 || un1) flag = 1'b1;
      end while (!fs1 && n < 100);
      checks++;
      if (n != 63 || bad !== 1'b0 || flag !== 1'b0) begin
        errors++;
        $display("FAIL div1_frame%0d: wait=%0d bclk_stall=%b pulse=%b want 63 0 0",
                 f, n, bad, flag);
      end
      if (f < 3) strobe(vals[f+1]);
    end
    capture(1, w, l, p);
    checks++;
    if (w !== {vals[3], vals[3]} || l !== 32'h0001_FFFE || p !== 1'b0) begin
      errors++;
      $display("FAIL div1_word: word=%h lr=%h stray=%b want %h 0001fffe 0",
               w, l, p, {vals[3], vals[3]});
    end
    wait_frame(10, n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL div1_tail: wait=%0d want 2", n);
    end
  endtask

  initial begin
    RESETn  = 1'b0;
    sel     = 1'b0;
    sample4 = '0;
    sample1 = '0;
    valid4  = 1'b0;
    valid1  = 1'b0;
    test_reset();
    test_startup("startup");
    test_mono();
    test_overrun();
    test_latch_collision();
    test_reset_mid();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
